// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    IDLE,
    WAIT
  } state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // Wide enough to hold the largest legal read latency.
  localparam int unsigned LAT_W = 3;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker; the port that did not win last time takes a tie.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       enable,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      if (req == 2'b11) begin
        gnt = (last == PORT1) ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: round-robin grant, one outstanding read, per-port read return.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_adr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_adr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_e           state_q, state_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic             rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic [1:0]       gnt;
  logic             accept, sel, sel_we, capture;

  rr_arb2 u_rr_arb2 (
    .req    ({m1_req, m0_req}),
    .last   (last_q),
    .enable (state_q == IDLE),
    .gnt    (gnt)
  );

  assign m0_gnt = gnt[0];
  assign m1_gnt = gnt[1];
  assign accept = |gnt;
  assign sel    = gnt[1];
  assign sel_we = sel ? m1_we : m0_we;
  assign busy   = (state_q != IDLE) || (m0_req && !m0_gnt);

  // Memory bus is zeroed outside accept cycles so idle traffic is easy to spot.
  always_comb begin
    mem_en    = accept;
    mem_we    = 1'b0;
    mem_adr   = '0;
    mem_wdata = '0;
    if (accept) begin
      mem_we    = sel_we;
      mem_adr   = sel ? m1_adr : m0_adr;
      mem_wdata = sel ? m1_wdata : m0_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          last_d = sel;
          if (!sel_we) begin
            owner_d = sel;
            cnt_d   = LAT_W'(READ_LAT);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == LAT_W'(1)) begin
          capture = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - LAT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      owner_q   <= PORT0;
      last_q    <= PORT1;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      rvalid0_q <= capture && (owner_q == PORT0);
      rvalid1_q <= capture && (owner_q == PORT1);
      if (capture && (owner_q == PORT0)) rdata0_q <= mem_rdata;
      if (capture && (owner_q == PORT1)) rdata1_q <= mem_rdata;
    end
  end

  assign m0_rvalid = rvalid0_q;
  assign m1_rvalid = rvalid1_q;
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: three instances (READ_LAT 1, 3, 4) share requester stimulus.
module tb_dmem_arbiter;

  localparam bit H = 1'b1;
  localparam bit L = 1'b0;
  localparam logic [31:0] Z = 32'h0;

  typedef struct {
    bit          rst;
    bit          r0, w0;
    logic [31:0] a0, d0;
    bit          r1, w1;
    logic [31:0] a1, d1;
    bit          g0, g1, en, we;
    logic [31:0] ma, md;
    bit          bsy, rv0, rv1;
  } vec_t;

  typedef struct {
    logic        port;
    logic [31:0] data;
  } exp_t;

  logic        clk, rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_adr, m0_wdata, m1_adr, m1_wdata;
  logic [2:0]  m0_gnt_w, m1_gnt_w, m0_rv_w, m1_rv_w, mem_en_w, mem_we_w, busy_w;
  logic [31:0] m0_rd_w [3];
  logic [31:0] m1_rd_w [3];
  logic [31:0] mem_adr_w [3];
  logic [31:0] mem_wd_w [3];
  logic [31:0] mem_rd_w [3];
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;
  vec_t        vecs[$];
  exp_t        sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance 0 memory returns adr+0x1000 of the last read; the others return a cycle stamp.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [31:0] rd_adr = '0;
    always @(posedge clk) if (mem_en_w[g] && !mem_we_w[g]) rd_adr <= mem_adr_w[g];
    assign mem_rd_w[g] = (g == 0) ? rd_adr + 32'h1000 : {16'hC0DE, cyc[15:0]};

    dmem_arbiter #(
      .ADDR_W   (32),
      .DATA_W   (32),
      .READ_LAT ((g == 0) ? 1 : (g == 1) ? 3 : 4)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .m0_req    (m0_req),
      .m0_we     (m0_we),
      .m0_adr    (m0_adr),
      .m0_wdata  (m0_wdata),
      .m0_gnt    (m0_gnt_w[g]),
      .m0_rvalid (m0_rv_w[g]),
      .m0_rdata  (m0_rd_w[g]),
      .m1_req    (m1_req),
      .m1_we     (m1_we),
      .m1_adr    (m1_adr),
      .m1_wdata  (m1_wdata),
      .m1_gnt    (m1_gnt_w[g]),
      .m1_rvalid (m1_rv_w[g]),
      .m1_rdata  (m1_rd_w[g]),
      .mem_en    (mem_en_w[g]),
      .mem_we    (mem_we_w[g]),
      .mem_adr   (mem_adr_w[g]),
      .mem_wdata (mem_wd_w[g]),
      .mem_rdata (mem_rd_w[g]),
      .busy      (busy_w[g])
    );
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_pop(input logic port, input logic [31:0] data);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_underflow: got rvalid on port %0d data %h expected none", port, data);
    end else begin
      e = sb.pop_front();
      chk1("sb_port", port, e.port);
      chk32("sb_data", data, e.data);
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive_idle();
    m0_req = 1'b0; m0_we = 1'b0; m0_adr = Z; m0_wdata = Z;
    m1_req = 1'b0; m1_we = 1'b0; m1_adr = Z; m1_wdata = Z;
  endtask

  initial begin
    vec_t        v;
    int unsigned a;
    string       n;

    rst_n = 1'b0;
    drive_idle();

    // Write / back-to-back write / alternating read / read-during-WAIT sequence on READ_LAT=1.
    vecs.push_back(vec_t'{L, H,H,32'h10,32'hDEADBEEF, L,L,Z,Z, H,L,H,H,32'h10,32'hDEADBEEF, L,L,L});
    vecs.push_back(vec_t'{L, L,L,Z,Z, L,L,Z,Z, L,L,L,L,Z,Z, L,L,L});
    for (int i = 0; i < 4; i++) begin
      vecs.push_back(vec_t'{L, L,L,Z,Z, H,H,32'(i),32'hA0 + 32'(i),
                            L,H,H,H,32'(i),32'hA0 + 32'(i), L,L,L});
    end
    vecs.push_back(vec_t'{L, L,L,Z,Z, L,L,Z,Z, L,L,L,L,Z,Z, L,L,L});
    vecs.push_back(vec_t'{H, H,L,32'h10,Z, H,L,32'h20,Z, H,L,H,L,32'h10,Z, L,L,L});
    vecs.push_back(vec_t'{L, H,L,32'h10,Z, H,L,32'h20,Z, L,L,L,L,Z,Z, H,L,L});
    vecs.push_back(vec_t'{L, H,L,32'h10,Z, H,L,32'h20,Z, L,H,H,L,32'h20,Z, H,H,L});
    vecs.push_back(vec_t'{L, H,L,32'h10,Z, H,L,32'h20,Z, L,L,L,L,Z,Z, H,L,L});
    vecs.push_back(vec_t'{L, H,L,32'h10,Z, H,L,32'h20,Z, H,L,H,L,32'h10,Z, L,L,H});
    vecs.push_back(vec_t'{L, H,L,32'h10,Z, H,L,32'h20,Z, L,L,L,L,Z,Z, H,L,L});
    vecs.push_back(vec_t'{L, H,L,32'h10,Z, H,L,32'h20,Z, L,H,H,L,32'h20,Z, H,H,L});
    vecs.push_back(vec_t'{L, L,L,Z,Z, L,L,Z,Z, L,L,L,L,Z,Z, H,L,L});
    vecs.push_back(vec_t'{L, L,L,Z,Z, L,L,Z,Z, L,L,L,L,Z,Z, L,L,H});
    vecs.push_back(vec_t'{H, L,L,Z,Z, H,L,32'h30,Z, L,H,H,L,32'h30,Z, L,L,L});
    vecs.push_back(vec_t'{L, H,L,32'h40,Z, L,L,Z,Z, L,L,L,L,Z,Z, H,L,L});
    vecs.push_back(vec_t'{L, H,L,32'h40,Z, L,L,Z,Z, H,L,H,L,32'h40,Z, L,L,H});
    vecs.push_back(vec_t'{L, L,L,Z,Z, L,L,Z,Z, L,L,L,L,Z,Z, H,L,L});
    vecs.push_back(vec_t'{L, L,L,Z,Z, L,L,Z,Z, L,L,L,L,Z,Z, L,H,L});

    // Reset state, sampled while reset is held.
    @(negedge clk);
    @(negedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      chk1($sformatf("rst%0d.mem_en", g), mem_en_w[g], 1'b0);
      chk1($sformatf("rst%0d.busy", g), busy_w[g], 1'b0);
      chk1($sformatf("rst%0d.m0_rvalid", g), m0_rv_w[g], 1'b0);
      chk1($sformatf("rst%0d.m1_rvalid", g), m1_rv_w[g], 1'b0);
      chk32($sformatf("rst%0d.m0_rdata", g), m0_rd_w[g], Z);
      chk32($sformatf("rst%0d.m1_rdata", g), m1_rd_w[g], Z);
      chk32($sformatf("rst%0d.mem_adr", g), mem_adr_w[g], Z);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      if (v.rst) pulse_reset();
      m0_req = v.r0; m0_we = v.w0; m0_adr = v.a0; m0_wdata = v.d0;
      m1_req = v.r1; m1_we = v.w1; m1_adr = v.a1; m1_wdata = v.d1;
      #1;
      n = $sformatf("v%0d", i);
      chk1({n, ".m0_gnt"}, m0_gnt_w[0], v.g0);
      chk1({n, ".m1_gnt"}, m1_gnt_w[0], v.g1);
      chk1({n, ".mem_en"}, mem_en_w[0], v.en);
      chk1({n, ".mem_we"}, mem_we_w[0], v.we);
      chk32({n, ".mem_adr"}, mem_adr_w[0], v.ma);
      chk32({n, ".mem_wdata"}, mem_wd_w[0], v.md);
      chk1({n, ".busy"}, busy_w[0], v.bsy);
      chk1({n, ".m0_rvalid"}, m0_rv_w[0], v.rv0);
      chk1({n, ".m1_rvalid"}, m1_rv_w[0], v.rv1);
      if (m0_rv_w[0]) sb_pop(1'b0, m0_rd_w[0]);
      if (m1_rv_w[0]) sb_pop(1'b1, m1_rd_w[0]);
      if ((v.g0 || v.g1) && !v.we) sb.push_back(exp_t'{v.g1, (v.g1 ? v.a1 : v.a0) + 32'h1000});
      @(negedge clk);
    end
    drive_idle();
    chk32("sb_leftover", 32'(sb.size()), Z);
    chk32("hold.m0_rdata", m0_rd_w[0], 32'h1040);
    chk32("hold.m1_rdata", m1_rd_w[0], 32'h1030);

    // READ_LAT=3: reset one cycle after a read accept drops the read.
    pulse_reset();
    m0_req = 1'b1; m0_adr = 32'h50;
    #1;
    chk1("l3.accept", m0_gnt_w[1], 1'b1);
    @(negedge clk);
    m0_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk1("l3.rst_mem_en", mem_en_w[1], 1'b0);
    chk1("l3.rst_busy", busy_w[1], 1'b0);
    chk32("l3.rst_m0_rdata", m0_rd_w[1], Z);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk1($sformatf("l3.no_rv0_%0d", k), m0_rv_w[1], 1'b0);
      chk1($sformatf("l3.no_rv1_%0d", k), m1_rv_w[1], 1'b0);
      @(negedge clk);
    end
    m0_req = 1'b1; m0_adr = 32'h50;
    m1_req = 1'b1; m1_adr = 32'h70;
    #1;
    chk1("l3.conflict_g0", m0_gnt_w[1], 1'b1);
    chk1("l3.conflict_g1", m1_gnt_w[1], 1'b0);
    @(negedge clk);
    m0_req = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      #1;
      chk1($sformatf("l3.g1_at_%0d", k), m1_gnt_w[1], k == 4);
      chk1($sformatf("l3.rv0_at_%0d", k), m0_rv_w[1], k == 4);
      @(negedge clk);
    end
    drive_idle();
    repeat (5) @(negedge clk);

    // READ_LAT=4: rvalid exactly five cycles after accept with data from the fourth.
    pulse_reset();
    m0_req = 1'b1; m0_adr = 32'h60;
    #1;
    chk1("l4.accept", m0_gnt_w[2], 1'b1);
    a = cyc;
    @(negedge clk);
    m0_req = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      #1;
      chk1($sformatf("l4.rv0_at_%0d", k), m0_rv_w[2], k == 5);
      chk1($sformatf("l4.rv1_at_%0d", k), m1_rv_w[2], 1'b0);
      if (k == 5) chk32("l4.rdata", m0_rd_w[2], {16'hC0DE, 16'(a + 32'd4)});
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
